// File: rtl/uart_pkg.sv
// Shared types for the UART blocks: transmitter FSM states and parity mode encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is ignored
// even when a pop happens in the same cycle.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a write FIFO: programmable baud divider, data width,
// parity and stop bits, with back-to-back frames when the FIFO stays non-empty.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          wr,
  input  logic [DATA_BITS-1:0]          d_in,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          txd,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overflow
);

  localparam int BW = $clog2(DATA_BITS);

  tx_state_e             state_q;
  logic [DIV_W-1:0]      baud_q, div_q;
  logic [BW-1:0]         bit_q;
  logic                  stop_q, two_q, txd_q, ovf_q, par_q;
  logic [1:0]            mode_q;
  logic [DATA_BITS-1:0]  sh_q, fifo_dout;
  logic                  fifo_full, fifo_empty;
  logic                  bit_end, last_stop, frame_end, pop;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (wr),
    .pop   (pop),
    .din   (d_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign bit_end   = (baud_q == div_q);
  assign last_stop = stop_q || !two_q;
  assign frame_end = (state_q == ST_STOP) && bit_end && last_stop;
  // Pop from IDLE, or at the very end of a frame so the next start bit follows without a gap.
  assign pop       = !fifo_empty && ((state_q == ST_IDLE) || frame_end);

  assign txd        = txd_q;
  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_end;
  assign overflow   = ovf_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      two_q   <= 1'b0;
      mode_q  <= PAR_NONE;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q  <= wr && fifo_full;
      baud_q <= ((state_q == ST_IDLE) || bit_end) ? '0 : baud_q + 1'b1;
      if (pop) begin
        state_q <= ST_START;
        txd_q   <= 1'b0;
        div_q   <= baud_div;
        mode_q  <= parity_mode;
        two_q   <= two_stop;
        stop_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_START: if (bit_end) begin
            state_q <= ST_DATA;
            bit_q   <= '0;
            txd_q   <= sh_q[0];
          end
          ST_DATA: if (bit_end) begin
            if (bit_q == BW'(DATA_BITS - 1)) begin
              if (par_enabled(mode_q)) begin
                state_q <= ST_PARITY;
                txd_q   <= par_q;
              end else begin
                state_q <= ST_STOP;
                txd_q   <= 1'b1;
                stop_q  <= 1'b0;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
              txd_q <= sh_q[1];
            end
          end
          ST_PARITY: if (bit_end) begin
            state_q <= ST_STOP;
            txd_q   <= 1'b1;
            stop_q  <= 1'b0;
          end
          ST_STOP: if (bit_end) begin
            if (!last_stop) begin
              stop_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              txd_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Shift register and parity bit are pure data: loaded on pop, no reset needed.
  always_ff @(posedge clk) begin
    if (pop) begin
      sh_q  <= fifo_dout;
      par_q <= (^fifo_dout) ^ (parity_mode == PAR_ODD);
    end else if ((state_q == ST_DATA) && bit_end) begin
      sh_q  <= sh_q >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: expected txd bit sequences are built from the
// written byte, parity mode and stop count, and checked cycle by cycle.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        wr = 1'b0;
  logic [7:0]  d_in = '0;
  logic [15:0] baud_div = '0;
  logic [1:0]  parity_mode = '0;
  logic        two_stop = 1'b0;
  logic        txd, full, empty, busy, frame_done, overflow;
  logic [2:0]  level;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_fifo #(
    .DATA_BITS  (8),
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .wr          (wr),
    .d_in        (d_in),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .txd         (txd),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .busy        (busy),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_txd_low(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (txd !== 1'b0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start_seen"}, (n < max_cyc), 1);
  endtask

  // Entered in the first cycle of the start bit; returns in the first cycle after the frame.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] pm, input logic two,
                           input int div, input string tag);
    logic bits [0:11];
    int   nb, ok, fd_cnt;
    logic fd_last, busy_last;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
    if (pm == 2'd1 || pm == 2'd2) begin
      bits[nb] = (^d) ^ (pm == 2'd2);
      nb++;
    end
    bits[nb] = 1'b1;
    nb++;
    if (two) begin
      bits[nb] = 1'b1;
      nb++;
    end
    fd_cnt    = 0;
    fd_last   = 1'b0;
    busy_last = 1'b0;
    for (int b = 0; b < nb; b++) begin
      ok = 0;
      for (int c = 0; c <= div; c++) begin
        if (txd === bits[b]) ok++;
        if (frame_done === 1'b1) fd_cnt++;
        if (b == nb - 1 && c == div) begin
          fd_last   = frame_done;
          busy_last = busy;
        end
        @(negedge clk);
        wr = 1'b0;
      end
      chk($sformatf("%s_bit%0d", tag, b), ok, div + 1);
    end
    chk({tag, "_frame_done_last"}, fd_last, 1);
    chk({tag, "_frame_done_count"}, fd_cnt, 1);
    chk({tag, "_busy_last"}, busy_last, 1);
  endtask

  task automatic idle_high(input string tag, input int cycles);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      if (txd !== 1'b1) lows++;
      @(negedge clk);
    end
    chk({tag, "_txd_low_cycles"}, lows, 0);
  endtask

  initial begin
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    clr = 1'b0;
    @(negedge clk);

    // Basic frame: 0xA5, even parity, one stop, 4 clk per bit
    baud_div = 16'd3; parity_mode = 2'd1; two_stop = 1'b0;
    d_in = 8'hA5; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    chk("lat_level1", level, 1);
    chk("lat_txd_idle", txd, 1);
    chk("lat_busy0", busy, 0);
    @(negedge clk);
    chk("lat_txd_start", txd, 0);
    chk("lat_busy1", busy, 1);
    chk("lat_level0", level, 0);
    run_frame(8'hA5, 2'd1, 1'b0, 3, "basic");
    chk("basic_busy_after", busy, 0);
    idle_high("basic_idle", 5);

    // Odd parity, two stop bits, 0x00
    baud_div = 16'd1; parity_mode = 2'd2; two_stop = 1'b1;
    d_in = 8'h00; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    wait_txd_low("odd2", 10);
    run_frame(8'h00, 2'd2, 1'b1, 1, "odd2");
    chk("odd2_busy_after", busy, 0);

    // Back-to-back: three frames, no parity
    baud_div = 16'd1; parity_mode = 2'd0; two_stop = 1'b0;
    d_in = 8'h55; wr = 1'b1;
    @(negedge clk);
    d_in = 8'hAA;
    @(negedge clk);
    chk("b2b_first_start", txd, 0);
    d_in = 8'h0F;
    run_frame(8'h55, 2'd0, 1'b0, 1, "b2b0");
    chk("b2b0_busy_boundary", busy, 1);
    run_frame(8'hAA, 2'd0, 1'b0, 1, "b2b1");
    chk("b2b1_busy_boundary", busy, 1);
    run_frame(8'h0F, 2'd0, 1'b0, 1, "b2b2");
    chk("b2b_busy_after", busy, 0);

    // Overflow: four writes fill the FIFO during frame 0x11, fifth is dropped
    baud_div = 16'd3; parity_mode = 2'd0; two_stop = 1'b0;
    d_in = 8'h11; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    wait_txd_low("ovf", 10);
    for (int k = 0; k < 4; k++) begin
      d_in = 8'h22 + 8'(k * 8'h11);
      wr = 1'b1;
      @(negedge clk);
    end
    chk("ovf_level4", level, 4);
    chk("ovf_full", full, 1);
    chk("ovf_no_pulse_yet", overflow, 0);
    d_in = 8'h66;
    @(negedge clk);
    wr = 1'b0;
    chk("ovf_pulse", overflow, 1);
    chk("ovf_level_kept", level, 4);
    @(negedge clk);
    chk("ovf_pulse_one_cycle", overflow, 0);
    n = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ovf_first_frame_done", (n < 200), 1);
    @(negedge clk);
    run_frame(8'h22, 2'd0, 1'b0, 3, "ovf_w1");
    run_frame(8'h33, 2'd0, 1'b0, 3, "ovf_w2");
    run_frame(8'h44, 2'd0, 1'b0, 3, "ovf_w3");
    run_frame(8'h55, 2'd0, 1'b0, 3, "ovf_w4");
    chk("ovf_busy_after", busy, 0);
    chk("ovf_empty_after", empty, 1);
    idle_high("ovf_dropped", 50);

    // Config latch: baud_div changed mid-frame applies only to the next frame
    baud_div = 16'd7; parity_mode = 2'd0; two_stop = 1'b0;
    d_in = 8'h3C; wr = 1'b1;
    @(negedge clk);
    d_in = 8'hC3;
    @(negedge clk);
    wr = 1'b0;
    chk("cfg_start", txd, 0);
    baud_div = 16'd1;
    run_frame(8'h3C, 2'd0, 1'b0, 7, "cfg_slow");
    run_frame(8'hC3, 2'd0, 1'b0, 1, "cfg_fast");
    chk("cfg_busy_after", busy, 0);

    // Reset mid-frame with a second word queued
    baud_div = 16'd3; parity_mode = 2'd0; two_stop = 1'b0;
    d_in = 8'h00; wr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr = 1'b0;
    chk("mrst_start", txd, 0);
    repeat (6) @(negedge clk);
    chk("mrst_pre_txd", txd, 0);
    chk("mrst_pre_level", level, 1);
    #2 clr = 1'b1;
    #1 chk("mrst_txd_async", txd, 1);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("mrst_empty", empty, 1);
    chk("mrst_level", level, 0);
    chk("mrst_busy", busy, 0);
    idle_high("mrst_idle", 30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a write FIFO and a programmable baud divider. It replaces the fixed 8-bit, even-parity, x16-clocked transmitter: one system clock, a configurable data width, runtime-selectable parity and stop-bit count, and back-to-back frames with no idle gap. It sits between a CPU or bus write port and the txd pin.

## Interface
- DATA_BITS, 8: data bits per frame, legal range 5..8; only d_in[DATA_BITS-1:0] is sent.
- FIFO_DEPTH, 4: FIFO entries, a power of two, at least 2.
- DIV_W, 16: width of baud_div.
- clk  in  1  system clock, rising edge.
- clr  in  1  reset; asynchronous, active-high.
- wr  in  1  write strobe, active-high; one push per cycle high.
- d_in  in  DATA_BITS  data byte from the CPU.
- baud_div  in  DIV_W  bit period is baud_div+1 clk cycles.
- parity_mode  in  2  0 none, 1 even, 2 odd, 3 none.
- two_stop  in  1  1 sends two stop bits, 0 sends one.
- txd  out  1  serial output, idles high.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds no entries.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse at the end of the last stop bit.
- overflow  out  1  one-cycle pulse when a write is dropped.

## Operation
- Reset values: txd=1, full=0, empty=1, level=0, busy=0, frame_done=0, overflow=0. Reset also flushes the FIFO and forces the FSM to IDLE.
- Write acceptance: a write is accepted iff level<FIFO_DEPTH at the start of the cycle.
  - A pop in the same cycle does not rescue a write into a full FIFO.
  - A dropped write leaves the FIFO unchanged and pulses overflow.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves level unchanged.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE: if the FIFO is non-empty, pop the word, latch it and latch the config, then go to START.
  - The latched config is parity_mode, two_stop and baud_div.
- START: drive txd=0 for one bit period.
- DATA: send DATA_BITS bits LSB first. The bit index counts 0..DATA_BITS-1.
- PARITY: entered only if the latched mode is 1 or 2.
  - Even: txd = XOR of the data bits.
  - Odd: txd = the inverse of that XOR.
- STOP: drive txd=1 for one bit period, or two if two_stop is latched.
  - At the end of the last stop bit, pulse frame_done.
  - If the FIFO is non-empty, pop and go directly to START with no idle bit. Otherwise go to IDLE.
- Config changes mid-frame have no effect until the next pop.
- busy=1 in every state except IDLE.
- Baud counter: counts 0..latched baud_div and restarts at 0 on every state or bit transition.
  - baud_div=0 gives one clk per bit.
- Frame length in bits: 1 + DATA_BITS + (parity ? 1 : 0) + (two_stop ? 2 : 1).

## Timing
- txd is registered; it must never glitch.
- Latency: wr high at edge N into an empty, idle block → level=1 after edge N → pop and txd=0 after edge N+1.
- Each bit lasts exactly baud_div+1 cycles. A full frame lasts frame_bits*(baud_div+1) cycles.
- frame_done is high in the final cycle of the last stop bit. In that same cycle busy stays 1.
- With a back-to-back frame, busy stays 1 through the boundary and the next start bit begins on the following edge.
- Reset mid-frame: txd returns to 1 asynchronously and the partial frame is lost. After clr deasserts, the block waits for a new write.

## Structure
- Package uart_pkg holds the FSM state enum and the parity mode localparams (PAR_NONE, PAR_EVEN, PAR_ODD).
- Sub-module uart_fifo: synchronous FIFO with parameters DEPTH and WIDTH, and ports clk, clr, push, pop, din, dout, full, empty, level. It is reused by the future receiver.
- The top level contains the FSM, the baud counter, the bit counter and the shift register.

## Test plan
- Reset: assert clr mid-frame → txd=1 immediately; empty=1, level=0, busy=0 after release.
- Basic frame: baud_div=3, parity_mode=1, two_stop=0, write 0xA5 → txd sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 clks. frame_done fires at cycle 44 after the pop.
- Odd parity with two stops: DATA_BITS=8, write 0x00 with parity_mode=2, two_stop=1 → parity bit 1, then two stop bits; frame is 12 bits.
- Back-to-back: write 0x55, 0xAA, 0x0F in consecutive cycles with parity_mode=0 → three 10-bit frames with no idle bit between them. busy stays 1 throughout; frame_done pulses 3 times.
- Overflow: FIFO_DEPTH=4; while the first frame sends, write 5 more words → the first 4 are accepted and full=1. The 5th write pulses overflow, level stays 4, and the dropped word never appears on txd.
- Config latch: start a frame with baud_div=7, then change baud_div to 1 mid-frame → the current frame keeps 8-clk bits; the next frame uses 2-clk bits.
